// File: rtl/wb_dma_arbiter.sv
// Two-master Wishbone arbiter that shares one slave between a CPU (m0) and a
// DMA engine (m1). Each grant covers exactly one single-beat transfer. The DMA
// normally wins, but only for a bounded run of grants while the CPU is waiting.
// A per-grant ack timeout aborts a transfer the slave never answers.
module wb_dma_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2,
    BUBBLE = 2'd3
  } state_e;

  localparam logic [2:0] StarveMax  = 3'(STARVE_LIMIT);
  localparam logic [7:0] TimeoutMax = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [2:0] starveCnt_q, starveCnt_d;
  logic [7:0] tmoCnt_q, tmoCnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic       req0, req1;
  logic       grantCyc;
  logic       timedOut;

  assign req0     = m0_cyc_i & m0_stb_i;
  assign req1     = m1_cyc_i & m1_stb_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = gnt_q;

  // The owner's cyc line; low while granted means the master walked away.
  always_comb begin
    grantCyc = 1'b0;
    if (state_q == GNT_M0) begin
      grantCyc = m0_cyc_i;
    end else if (state_q == GNT_M1) begin
      grantCyc = m1_cyc_i;
    end
  end

  // Timeout only counts for a live transfer; a same-cycle ack wins over it.
  assign timedOut = grantCyc & ~s_ack_i & (tmoCnt_q == TimeoutMax);

  // Route the owning master onto the slave bus and return ack/err to it alone.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = 32'h0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      GNT_M0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = timedOut;
      end
      GNT_M1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = timedOut;
      end
      default: begin
      end
    endcase
  end

  // Arbitration, grant release and the starvation / timeout counters.
  always_comb begin
    state_d     = state_q;
    starveCnt_d = starveCnt_q;
    tmoCnt_d    = tmoCnt_q;
    case (state_q)
      IDLE: begin
        if (req1 && (!req0 || (starveCnt_q < StarveMax))) begin
          state_d  = GNT_M1;
          tmoCnt_d = 8'h0;
          if (req0) begin
            starveCnt_d = (starveCnt_q == 3'd7) ? 3'd7 : starveCnt_q + 3'd1;
          end else begin
            starveCnt_d = 3'd0;
          end
        end else if (req0) begin
          state_d     = GNT_M0;
          tmoCnt_d    = 8'h0;
          starveCnt_d = 3'd0;
        end
      end
      GNT_M0, GNT_M1: begin
        if (s_ack_i || !grantCyc || timedOut) begin
          state_d = BUBBLE;
        end else begin
          tmoCnt_d = tmoCnt_q + 8'h1;
        end
      end
      BUBBLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The grant vector is decoded from the next state so it is a clean register.
  always_comb begin
    case (state_d)
      GNT_M0:  gnt_d = 2'b01;
      GNT_M1:  gnt_d = 2'b10;
      default: gnt_d = 2'b00;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      starveCnt_q <= 3'd0;
      tmoCnt_q    <= 8'h0;
      gnt_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
      tmoCnt_q    <= tmoCnt_d;
      gnt_q       <= gnt_d;
    end
  end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Testbench for wb_dma_arbiter: fixed vector table, directed multi-cycle
// sequences and randomized traffic, all checked against a transaction-level
// model of who owns the slave and for how long.
module tb_wb_dma_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  localparam logic [31:0] A0 = 32'h38000100;
  localparam logic [31:0] A1 = 32'h380002b4;
  localparam logic [31:0] D0 = 32'h55AA0000;
  localparam logic [31:0] D1 = 32'h0000000A;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [3:0]  m0_sel_i = 4'h0;
  logic [31:0] m0_adr_i = 32'h0, m0_dat_i = 32'h0;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [3:0]  m1_sel_i = 4'h0;
  logic [31:0] m1_adr_i = 32'h0, m1_dat_i = 32'h0;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i = 32'h0;
  logic        s_ack_i = 1'b0;
  logic [1:0]  gnt_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the slave, whether the turnaround cycle is
  // pending, how long the owner has waited, and the current DMA run length.
  int ownerM    = -1;
  bit coolDown  = 1'b0;
  int waited    = 0;
  int dmaStreak = 0;

  typedef struct packed {
    logic        c0, c1, w1, ack;
    logic [31:0] sdat;
    logic [1:0]  eGnt;
    logic        eCyc, eWe, eAck0, eAck1;
    logic [1:0]  eErr;
  } vec_t;

  vec_t vecs [14];

  wb_dma_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  // 100 MHz clock.
  always #5 wb_clk_i = ~wb_clk_i;

  // Hard stop in case something upstream ever blocks.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic void modelReset();
    ownerM    = -1;
    coolDown  = 1'b0;
    waited    = 0;
    dmaStreak = 0;
  endfunction

  // Expected outputs for the current cycle from the model and the live inputs.
  function automatic void modelCompare();
    logic [70:0] expSlave;
    logic        ack0, ack1, err0, err1;
    logic [1:0]  expGnt;
    expSlave = '0;
    ack0 = 1'b0; ack1 = 1'b0; err0 = 1'b0; err1 = 1'b0;
    expGnt = 2'b00;
    if (ownerM == 0) begin
      expSlave = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
      ack0     = s_ack_i;
      err0     = m0_cyc_i && !s_ack_i && (waited == TMO);
      expGnt   = 2'b01;
    end else if (ownerM == 1) begin
      expSlave = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
      ack1     = s_ack_i;
      err1     = m1_cyc_i && !s_ack_i && (waited == TMO);
      expGnt   = 2'b10;
    end
    checkOutput("slaveBus",
      128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}), 128'(expSlave));
    checkOutput("masterResp",
      128'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o}),
      128'({ack0, err0, ack1, err1, s_dat_i, s_dat_i}));
    checkOutput("grant", 128'(gnt_o), 128'(expGnt));
  endfunction

  // Advance the model across one clock edge.
  function automatic void modelAdvance();
    logic cyc, r0, r1;
    r0 = m0_cyc_i & m0_stb_i;
    r1 = m1_cyc_i & m1_stb_i;
    if (ownerM >= 0) begin
      cyc = (ownerM == 0) ? m0_cyc_i : m1_cyc_i;
      if (s_ack_i || !cyc || waited == TMO) begin
        ownerM   = -1;
        coolDown = 1'b1;
      end else begin
        waited++;
      end
    end else if (coolDown) begin
      coolDown = 1'b0;
    end else if (r1 && (!r0 || dmaStreak < STARVE)) begin
      ownerM    = 1;
      waited    = 0;
      dmaStreak = r0 ? ((dmaStreak < 7) ? dmaStreak + 1 : 7) : 0;
    end else if (r0) begin
      ownerM    = 0;
      waited    = 0;
      dmaStreak = 0;
    end
  endfunction

  task automatic finishCycle();
    @(posedge wb_clk_i);
    modelAdvance();
    #1;
  endtask

  // Inputs are already driven (posedge+1); settle, compare, cross the edge.
  task automatic applyStimulus();
    #2;
    modelCompare();
    finishCycle();
  endtask

  task automatic resetDut();
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    checkOutput("resetState",
      128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, gnt_o}), 128'(0));
    wb_rst_i = 1'b0;
    modelReset();
  endtask

  task automatic setMasters(logic c0, logic c1, logic w1);
    m0_cyc_i = c0; m0_stb_i = c0; m0_we_i = 1'b0; m0_sel_i = 4'hF;
    m0_adr_i = A0; m0_dat_i = D0;
    m1_cyc_i = c1; m1_stb_i = c1; m1_we_i = w1;   m1_sel_i = 4'hF;
    m1_adr_i = A1; m1_dat_i = D1;
  endtask

  initial begin
    int          order[$];
    int          starts[$];
    logic [1:0]  gntLog[16];
    logic        stbLog[16];
    logic        errLog[16];
    int          errFirst, errCount;
    bit          errSeen;
    logic [1:0]  expOrder[10];
    logic [3:0]  eSel;
    logic [31:0] eAdr, eSdat;

    // Cycle-by-cycle table: CPU read acked on its 3rd grant cycle, a late ack
    // in the turnaround cycle, a DMA write, then a DMA abandon after 2 cycles.
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       2'b00,1'b0,1'b0,1'b0,1'b0,2'b00};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       2'b01,1'b1,1'b0,1'b0,1'b0,2'b00};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       2'b01,1'b1,1'b0,1'b0,1'b0,2'b00};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,DB,          2'b01,1'b1,1'b0,1'b1,1'b0,2'b00};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,DB,          2'b00,1'b0,1'b0,1'b0,1'b0,2'b00};
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,       2'b00,1'b0,1'b0,1'b0,1'b0,2'b00};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,       2'b10,1'b1,1'b1,1'b0,1'b1,2'b00};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,       2'b00,1'b0,1'b0,1'b0,1'b0,2'b00};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       2'b00,1'b0,1'b0,1'b0,1'b0,2'b00};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       2'b10,1'b1,1'b0,1'b0,1'b0,2'b00};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       2'b10,1'b1,1'b0,1'b0,1'b0,2'b00};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,32'h0,       2'b10,1'b0,1'b0,1'b0,1'b0,2'b00};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,32'h12345678,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,32'h12345678,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00};

    expOrder = '{2'b10,2'b10,2'b10,2'b10,2'b01,2'b10,2'b10,2'b10,2'b10,2'b01};

    $display("[TB] reset and vector table");
    resetDut();
    for (int i = 0; i < 14; i++) begin
      setMasters(vecs[i].c0, vecs[i].c1, vecs[i].w1);
      s_ack_i = vecs[i].ack;
      s_dat_i = vecs[i].sdat;
      eSel  = (vecs[i].eGnt != 2'b00) ? 4'hF : 4'h0;
      eAdr  = (vecs[i].eGnt == 2'b01) ? A0 : (vecs[i].eGnt == 2'b10) ? A1 : 32'h0;
      eSdat = (vecs[i].eGnt == 2'b01) ? D0 : (vecs[i].eGnt == 2'b10) ? D1 : 32'h0;
      #2;
      checkOutput($sformatf("vector%0d", i),
        128'({gnt_o, s_cyc_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
              m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o}),
        128'({vecs[i].eGnt, vecs[i].eCyc, vecs[i].eWe, eSel, eAdr, eSdat,
              vecs[i].eAck0, vecs[i].eAck1, vecs[i].eErr, vecs[i].sdat}));
      modelCompare();
      finishCycle();
    end

    $display("[TB] both masters saturating, single-cycle slave");
    resetDut();
    setMasters(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 32; c++) begin
      if (gnt_o != 2'b00) begin
        order.push_back(int'(gnt_o));
        starts.push_back(c);
      end
      s_ack_i = (ownerM >= 0);
      s_dat_i = $urandom;
      applyStimulus();
    end
    checkOutput("grantCount", 128'(order.size() >= 10), 128'(1));
    for (int k = 0; k < 10 && k < order.size(); k++) begin
      checkOutput($sformatf("grantOrder%0d", k), 128'(order[k]), 128'(expOrder[k]));
      if (k > 0) begin
        checkOutput($sformatf("grantSpacing%0d", k), 128'(starts[k] - starts[k-1]), 128'(3));
      end
    end

    $display("[TB] DMA timeout with CPU pending");
    resetDut();
    errSeen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      setMasters(1'b1, !errSeen, 1'b0);
      s_ack_i = (ownerM == 0);
      s_dat_i = $urandom;
      #2;
      modelCompare();
      gntLog[c] = gnt_o;
      stbLog[c] = s_stb_o;
      errLog[c] = m1_err_o;
      if (m1_err_o) errSeen = 1'b1;
      finishCycle();
    end
    errFirst = -1;
    errCount = 0;
    for (int c = 0; c < 16; c++) begin
      if (errLog[c]) begin
        errCount++;
        if (errFirst < 0) errFirst = c;
      end
    end
    checkOutput("errCycle", 128'(errFirst), 128'(9));
    checkOutput("errPulses", 128'(errCount), 128'(1));
    checkOutput("errGrant", 128'(gntLog[9]), 128'(2'b10));
    checkOutput("stbAfterErr", 128'({stbLog[10], gntLog[10]}), 128'(0));
    checkOutput("cpuAfterErr", 128'(gntLog[12]), 128'(2'b01));

    $display("[TB] reset during CPU grant");
    resetDut();
    setMasters(1'b1, 1'b0, 1'b0);
    s_ack_i = 1'b0;
    for (int c = 0; c < 3; c++) applyStimulus();
    s_ack_i = 1'b1;
    #1;
    checkOutput("preResetGrant", 128'({s_cyc_o, gnt_o}), 128'({1'b1, 2'b01}));
    wb_rst_i = 1'b1;
    #1;
    checkOutput("resetMidXfer",
      128'({s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, gnt_o}), 128'(0));
    modelReset();
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    s_ack_i  = 1'b0;
    applyStimulus();
    checkOutput("regrantAfterReset", 128'(gnt_o), 128'(2'b01));
    s_ack_i = 1'b1;
    applyStimulus();
    s_ack_i = 1'b0;
    applyStimulus();

    $display("[TB] randomized traffic");
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) resetDut();
      m0_cyc_i = ($urandom_range(2) != 0);
      m0_stb_i = m0_cyc_i & ($urandom_range(3) != 0);
      m0_we_i  = 1'($urandom);
      m0_sel_i = 4'($urandom);
      m0_adr_i = $urandom;
      m0_dat_i = $urandom;
      m1_cyc_i = ($urandom_range(2) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(3) != 0);
      m1_we_i  = 1'($urandom);
      m1_sel_i = 4'($urandom);
      m1_adr_i = $urandom;
      m1_dat_i = $urandom;
      s_ack_i  = ($urandom_range(3) == 0);
      s_dat_i  = $urandom;
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_dma_arbiter.md
WB_DMA_ARBITER -- requirements
Module: wb_dma_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive DMA grants while the CPU is waiting (range 1..7).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles a granted transfer waits for s_ack_i before aborting (range 1..255).
REQ-003 SHALL have one clock and one reset: the clock is wb_clk_i, and the reset is wb_rst_i, asynchronous and active-high.
REQ-004 SHALL have the following ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  async active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  CPU master control
- m0_sel_i  in  4  CPU byte selects
- m0_adr_i, m0_dat_i  in  32 each  CPU address and write data
- m0_ack_o, m0_err_o  out  1 each  CPU acknowledge and abort
- m0_dat_o  out  32  CPU read data
- m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i[3:0], m1_adr_i[31:0], m1_dat_i[31:0]  in  DMA master, same meaning as m0
- m1_ack_o, m1_err_o  out  1 each  DMA acknowledge and abort
- m1_dat_o  out  32  DMA read data
- s_cyc_o, s_stb_o, s_we_o  out  1 each  shared slave control
- s_sel_o  out  4  slave byte selects
- s_adr_o, s_dat_o  out  32 each  slave address and write data
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  current grant: 01 = CPU, 10 = DMA, 00 = none

Function
REQ-005 SHALL implement a state register with states IDLE, GNT_M0, GNT_M1 and BUBBLE.
REQ-006 Request definition SHALL be: req0 = m0_cyc_i & m0_stb_i, and req1 = m1_cyc_i & m1_stb_i.
REQ-007 In IDLE, arbitration SHALL be as follows:
- req1 & (~req0 | starve_cnt < STARVE_LIMIT) -> GNT_M1.
- Otherwise, req0 -> GNT_M0.
- Otherwise, stay in IDLE.
REQ-008 starve_cnt (3-bit) SHALL update at each IDLE decision:
- +1 when GNT_M1 is chosen while req0 is high, saturating at 7.
- Cleared when GNT_M0 is chosen, or when GNT_M1 is chosen with req0 low.
REQ-009 In GNT_Mx, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL be driven combinationally from master x; in IDLE and BUBBLE, all slave outputs SHALL be 0.
REQ-010 mx_ack_o SHALL equal s_ack_i & (state == GNT_Mx); the non-granted master's ack_o and err_o SHALL be 0.
REQ-011 m0_dat_o and m1_dat_o SHALL both carry s_dat_i at all times; masters qualify the data with ack.
REQ-012 On s_ack_i in GNT_Mx, the FSM SHALL go to BUBBLE; BUBBLE SHALL go to IDLE unconditionally after one cycle.
- This gives the master one cycle to drop or renew stb.
- Minimum grant-to-grant spacing is therefore 3 cycles.
REQ-013 Grant SHALL be held for exactly one single-beat transfer; the arbiter SHALL never preempt a granted transfer.
REQ-014 Master abandon: in GNT_Mx with mx_cyc_i low and s_ack_i low, the FSM SHALL go to BUBBLE and forward no ack.
REQ-015 Timeout:
- tmo_cnt (8-bit) SHALL clear on entering GNT_Mx and increment each cycle in GNT_Mx without s_ack_i.
- When tmo_cnt == TIMEOUT, mx_err_o SHALL pulse for one cycle, the slave outputs SHALL drop in the next cycle, and the FSM SHALL go to BUBBLE.
REQ-016 Simultaneous s_ack_i and timeout SHALL resolve as ack (no err); simultaneous s_ack_i and cyc drop SHALL forward the ack.
REQ-017 s_ack_i arriving in IDLE or BUBBLE SHALL be ignored and not forwarded.
REQ-018 gnt_o SHALL be registered state-decoded: 01 in GNT_M0, 10 in GNT_M1, and 00 otherwise.

Reset
REQ-019 While wb_rst_i is high, the following SHALL hold:
- state = IDLE, starve_cnt = 0, tmo_cnt = 0, gnt_o = 00.
- All s_* outputs = 0, and all ack_o and err_o = 0.
REQ-020 Reset asserted mid-transfer SHALL immediately drop s_cyc_o and s_stb_o with no ack or err forwarded; after deassertion, arbitration SHALL restart from IDLE with starve_cnt = 0.

Verification
REQ-021 CPU only: m0 read at 0x38000100, slave acks on 3rd cycle with 0xDEADBEEF -> gnt_o = 01, m0_ack_o one cycle, m0_dat_o = 0xDEADBEEF, m1_ack_o = 0.
REQ-022 Both requesting continuously, STARVE_LIMIT = 4, slave acks in 1 cycle -> grant order M1, M1, M1, M1, M0, M1, M1, M1, M1, M0, with spacing of 3 cycles.
REQ-023 DMA write to 0x380002b4, data 0x0000000A, sel 1111 -> s_we_o = 1, s_sel_o = 1111, s_adr_o and s_dat_o match; m1_ack_o pulses.
REQ-024 TIMEOUT = 8, slave never acks m1 -> m1_err_o pulses at cycle 9 of grant, s_stb_o low the next cycle, then the pending m0 is granted.
REQ-025 m1 drops cyc after 2 grant cycles -> no ack forwarded, BUBBLE then IDLE; a late s_ack_i in BUBBLE is ignored.
REQ-026 Reset pulse during GNT_M0 -> s_cyc_o = 0 at once, gnt_o = 00; m0 re-request after reset is granted normally.
